// File: rtl/branch_metric_scheduler.sv
// rtl/branch_metric_scheduler.sv - time-multiplexes one hamming_distance unit over four codeword hypotheses per symbol
module branch_metric_scheduler #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sys,
    input  logic             in_parity,
    output logic             bmu_sys,
    output logic             bmu_parity,
    output logic [1:0]       bmu_codeword,
    input  logic [1:0]       bmu_errors,
    output logic             bm_valid,
    input  logic             bm_ready,
    output logic [7:0]       bm_out,
    output logic [1:0]       bm_min,
    output logic             bm_last,
    output logic [CNT_W-1:0] sym_cnt
);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             sys_q, sys_d;
    logic             par_q, par_d;
    logic [7:0]       slots_q, slots_d;
    logic [1:0]       min_q, min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_at_end;
    logic [1:0]       min4;

    function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

    assign cnt_at_end = (cnt_q == CNT_W'(FRAME_LEN - 1));
    // Slot 3 is still on the bus when the minimum is registered, so use it directly.
    assign min4 = min2(min2(slots_q[1:0], slots_q[3:2]), min2(slots_q[5:4], bmu_errors));

    assign in_ready     = (state_q == IDLE) && rst_n && !flush;
    assign bmu_sys      = sys_q;
    assign bmu_parity   = par_q;
    assign bmu_codeword = idx_q;
    assign bm_valid     = (state_q == OUT);
    assign bm_out       = slots_q;
    assign bm_min       = min_q;
    assign bm_last      = (state_q == OUT) && cnt_at_end;
    assign sym_cnt      = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sys_d   = sys_q;
        par_d   = par_q;
        slots_d = slots_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            slots_d = 8'h00;
            min_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sys_d   = in_sys;
                        par_d   = in_parity;
                        idx_d   = 2'd0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    slots_d[{idx_q, 1'b0} +: 2] = bmu_errors;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        min_d   = min4;
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (bm_ready) begin
                        state_d = IDLE;
                        cnt_d   = cnt_at_end ? '0 : cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            sys_q   <= 1'b0;
            par_q   <= 1'b0;
            slots_q <= 8'h00;
            min_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sys_q   <= sys_d;
            par_q   <= par_d;
            slots_q <= slots_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_metric_scheduler.sv
// tb/tb_branch_metric_scheduler.sv - directed self-checking bench for branch_metric_scheduler
module tb_branch_metric_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_sys, in_parity, bm_ready;
    logic       in_ready, bmu_sys, bmu_parity, bm_valid, bm_last;
    logic [1:0] bmu_codeword, bmu_errors, bm_min;
    logic [7:0] bm_out;
    logic [7:0] sym_cnt;
    logic       force3;
    logic [1:0] diff;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Shared distance unit model; force3 injects out-of-range distances.
    always_comb begin
        diff       = bmu_codeword ^ {bmu_parity, bmu_sys};
        bmu_errors = force3 ? 2'd3 : ({1'b0, diff[0]} + {1'b0, diff[1]});
    end

    branch_metric_scheduler #(.FRAME_LEN(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sys(in_sys), .in_parity(in_parity),
        .bmu_sys(bmu_sys), .bmu_parity(bmu_parity), .bmu_codeword(bmu_codeword),
        .bmu_errors(bmu_errors), .bm_valid(bm_valid), .bm_ready(bm_ready),
        .bm_out(bm_out), .bm_min(bm_min), .bm_last(bm_last), .sym_cnt(sym_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_sym(input logic s, input logic p, input logic [7:0] eo,
                           input logic [1:0] em, input logic el);
        in_valid = 1'b1; in_sys = s; in_parity = p; bm_ready = 1'b1;
        #1 chk("in_ready_accept", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("codeword_step", bmu_codeword, k);
            chk("bm_valid_calc", bm_valid, 0);
            cyc();
        end
        #1;
        chk("bm_valid_out", bm_valid, 1);
        chk("bm_out", bm_out, eo);
        chk("bm_min", bm_min, em);
        chk("bm_last", bm_last, el);
        chk("in_ready_out", in_ready, 0);
        chk("codeword_out", bmu_codeword, 0);
        cyc();
        #1 chk("bm_valid_after_hs", bm_valid, 0);
    endtask

    logic [7:0] exp_tab [4];

    initial begin
        exp_tab[0] = 8'h94; exp_tab[1] = 8'h61; exp_tab[2] = 8'h49; exp_tab[3] = 8'h16;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sys = 1'b0; in_parity = 1'b0;
        bm_ready = 1'b0; force3 = 1'b0;
        cyc(); cyc();
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_bm_valid", bm_valid, 0);
        chk("rst_bm_out", bm_out, 8'h00);
        chk("rst_bm_min", bm_min, 0);
        chk("rst_bm_last", bm_last, 0);
        chk("rst_sym_cnt", sym_cnt, 0);
        chk("rst_codeword", bmu_codeword, 0);
        rst_n = 1'b1;
        #1 chk("in_ready_after_rst", in_ready, 1);

        run_sym(1'b1, 1'b0, 8'h61, 2'd0, 1'b0);
        run_sym(1'b0, 1'b0, 8'h94, 2'd0, 1'b0);
        run_sym(1'b1, 1'b1, 8'h16, 2'd0, 1'b0);
        #1 chk("sym_cnt_3", sym_cnt, 3);

        // Consumer stall with a competing symbol on the input
        bm_ready = 1'b0; in_valid = 1'b1; in_sys = 1'b0; in_parity = 1'b1;
        cyc();
        in_sys = 1'b1; in_parity = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stall_bm_valid", bm_valid, 1);
            chk("stall_bm_out", bm_out, 8'h49);
            chk("stall_in_ready", in_ready, 0);
            cyc();
        end
        in_valid = 1'b0; bm_ready = 1'b1;
        cyc();
        #1;
        chk("stall_release_valid", bm_valid, 0);
        chk("stall_sym_cnt", sym_cnt, 4);
        chk("stall_idle", in_ready, 1);

        force3 = 1'b1;
        run_sym(1'b0, 1'b0, 8'hFF, 2'd3, 1'b0);
        force3 = 1'b0;

        // Flush during the second CALC cycle with a new symbol offered
        in_valid = 1'b1; in_sys = 1'b1; in_parity = 1'b0;
        cyc();
        in_valid = 1'b0;
        cyc();
        flush = 1'b1; in_valid = 1'b1;
        #1 chk("flush_in_ready", in_ready, 0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_bm_valid", bm_valid, 0);
        chk("flush_sym_cnt", sym_cnt, 0);
        chk("flush_bm_out", bm_out, 8'h00);
        chk("flush_bm_min", bm_min, 0);
        chk("flush_in_ready_idle", in_ready, 1);
        chk("flush_codeword", bmu_codeword, 0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            #1 chk("flush_no_valid", bm_valid, 0);
        end
        run_sym(1'b1, 1'b1, 8'h16, 2'd0, 1'b0);
        #1 chk("post_flush_cnt", sym_cnt, 1);

        // Reset while a bundle waits in OUT
        bm_ready = 1'b0; in_valid = 1'b1; in_sys = 1'b1; in_parity = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        #1 chk("pre_rst_valid", bm_valid, 1);
        rst_n = 1'b0;
        cyc();
        #1;
        chk("midrst_bm_valid", bm_valid, 0);
        chk("midrst_bm_out", bm_out, 8'h00);
        chk("midrst_bm_min", bm_min, 0);
        chk("midrst_bm_last", bm_last, 0);
        chk("midrst_sym_cnt", sym_cnt, 0);
        chk("midrst_bmu_sys", bmu_sys, 0);
        chk("midrst_bmu_parity", bmu_parity, 0);
        chk("midrst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1 chk("midrst_in_ready_rel", in_ready, 1);

        // Full frame, back to back
        for (int i = 0; i < 16; i++) begin
            logic [1:0] ps;
            ps = 2'(i);
            run_sym(ps[0], ps[1], exp_tab[ps], 2'd0, (i == 15));
        end
        #1 chk("frame_wrap_cnt", sym_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
